uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_cnt.sv | 16 +
 rtl/uart_tx.sv | 89 ++++++++
 tb/tb_uart_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type and frame helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int MAX_PACK = 9;
  function automatic int frame_bits(int pack_size, int parity_en, int stop_bits);
    return 1 + pack_size + parity_en + stop_bits;
  endfunction
  function automatic logic parity_bit(logic [MAX_PACK-1:0] data, logic even_par);
    return even_par ? ^data : ~^data;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, bit_end strobes on the last cycle of each bit while clear is low
module uart_baud_cnt #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = $clog2(CLK_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLK_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = !clear && cnt_q == LAST;
  always_comb cnt_d = (clear || bit_end) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serializer; valid/ready word in, registered tx_bit/tx_ready/tx_active/tx_done out
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int PACK_SIZE   = 8,
  parameter int PARITY_EN   = 0,
  parameter int EVEN_PAR    = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PACK_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_bit,
  output logic                 tx_active,
  output logic                 tx_done
);
  localparam int IW = $clog2(PACK_SIZE) + 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(PACK_SIZE - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  uart_state_t state_q, state_d;
  logic [PACK_SIZE-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic par_q, par_d;
  logic tx_bit_q, tx_bit_d, tx_done_q, tx_done_d, tx_ready_q, tx_active_q;
  logic bit_end, baud_clear;
  assign baud_clear = state_q == IDLE;
  uart_baud_cnt #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .clear(baud_clear), .bit_end(bit_end)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = START;
        shift_d = tx_data;
        par_d   = parity_bit(MAX_PACK'(tx_data), EVEN_PAR != 0);
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q == LAST_DATA ? '0 : idx_q + 1'b1;
        if (idx_q == LAST_DATA) state_d = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        idx_d = idx_q == LAST_STOP ? '0 : idx_q + 1'b1;
        if (idx_q == LAST_STOP) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // line level is derived from the next state so tx_bit only moves at bit boundaries
    tx_bit_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
    tx_done_d = state_q == STOP && state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      tx_bit_q    <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      tx_bit_q    <= tx_bit_d;
      tx_ready_q  <= state_d == IDLE;
      tx_active_q <= state_d != IDLE;
      tx_done_q   <= tx_done_d;
    end
  end
  assign tx_bit    = tx_bit_q;
  assign tx_ready  = tx_ready_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations checked cycle by cycle against a frame-level waveform model
module tb_uart_tx;
  localparam int C = 5;
  localparam int PEN [3] = '{1, 1, 0};
  localparam int EVN [3] = '{0, 1, 0};
  localparam int STB [3] = '{1, 2, 2};
  localparam logic [11:0] EXPV [2][3] = '{
    '{12'b010111111100, 12'b111111111100, 12'b011111111100},
    '{12'b011000000000, 12'b110000000000, 12'b011000000000}
  };
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic [2:0] tx_valid = '0;
  logic [2:0] tx_ready, tx_bit, tx_active, tx_done;
  int checks = 0, errors = 0;
  logic [3:0] q [3][$];
  always #5 clk = ~clk;
  uart_tx #(.CLK_PER_BIT(C), .PACK_SIZE(8), .PARITY_EN(1), .EVEN_PAR(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_bit(tx_bit[0]), .tx_active(tx_active[0]), .tx_done(tx_done[0]));
  uart_tx #(.CLK_PER_BIT(C), .PACK_SIZE(8), .PARITY_EN(1), .EVEN_PAR(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx_bit(tx_bit[1]), .tx_active(tx_active[1]), .tx_done(tx_done[1]));
  uart_tx #(.CLK_PER_BIT(C), .PACK_SIZE(8), .PARITY_EN(0), .EVEN_PAR(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .tx_bit(tx_bit[2]), .tx_active(tx_active[2]), .tx_done(tx_done[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] exp_now(int k);
    return q[k].size() != 0 ? q[k][0] : 4'b1010;
  endfunction
  // expected {tx_bit, tx_active, tx_ready, tx_done} per cycle: each frame level held C cycles, then one done cycle
  task automatic push_frame(int k, logic [7:0] d);
    logic lv [$];
    int n = $countones(d);
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (PEN[k] != 0) lv.push_back(EVN[k] != 0 ? n[0] : !n[0]);
    for (int i = 0; i < STB[k]; i++) lv.push_back(1'b1);
    foreach (lv[i]) repeat (C) q[k].push_back({lv[i], 3'b100});
    q[k].push_back(4'b1011);
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [3:0] e;
      e = exp_now(k);
      if (!rst) q[k].delete();
      else begin
        if (q[k].size() != 0) void'(q[k].pop_front());
        if (tx_valid[k] && e[1]) push_frame(k, tx_data);
      end
    end
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("u%0d_outs", k), {tx_bit[k], tx_active[k], tx_ready[k], tx_done[k]}, exp_now(k));
  end
  task automatic run_frame(input logic [7:0] d, input int di);
    int cnt [3];
    int dn [3];
    logic [11:0] v [3];
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0;
      dn[k] = 0;
      v[k] = '0;
    end
    @(negedge clk);
    tx_data = d;
    tx_valid = 3'b111;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      tx_valid = '0;
      for (int k = 0; k < 3; k++) begin
        if (tx_active[k]) begin
          if (cnt[k] % C == 2 && cnt[k] < 12 * C) v[k][cnt[k] / C] = tx_bit[k];
          cnt[k]++;
        end
        dn[k] += int'(tx_done[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_len_%0h", k, d), cnt[k], (1 + 8 + PEN[k] + STB[k]) * C);
      check($sformatf("u%0d_done_%0h", k, d), dn[k], 1);
      check($sformatf("u%0d_bits_%0h", k, d), v[k], EXPV[di][k]);
    end
  endtask
  initial begin
    int td, s1, rdy_bad;
    logic pa;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_frame(8'hFE, 0);
    run_frame(8'h00, 1);
    @(negedge clk);
    tx_data = 8'h55;
    tx_valid = 3'b001;
    td = -1; s1 = -1; rdy_bad = 0; pa = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (tx_done[0] && td < 0) td = i;
      if (tx_active[0] && !pa && td >= 0 && s1 < 0) begin
        s1 = i;
        tx_valid = '0;
      end
      if (tx_active[0] && tx_ready[0]) rdy_bad++;
      pa = tx_active[0];
      if (i == 0) tx_data = 8'hA3;
    end
    check("b2b_gap", s1 - td, 1);
    check("ready_in_frame", rdy_bad, 0);
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 3'b111;
    @(negedge clk);
    tx_valid = '0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      check($sformatf("u%0d_abort", k), {tx_bit[k], tx_active[k], tx_ready[k], tx_done[k]}, 4'b1010);
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 3'b111;
    @(negedge clk);
    tx_valid = '0;
    repeat (70) @(negedge clk);
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      tx_valid = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      rst = $urandom_range(0, 2999) != 0;
    end
    tx_valid = '0;
    rst = 1'b1;
    repeat (70) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
